// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams weights through a small FIFO, pairs them
// with input samples, then applies bias, ReLU and saturation before emitting one result.
module neuron_mac #(
  parameter int DATA_WIDTH   = 16,
  parameter int NO_OF_WEIGHT = 784,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 48,
  parameter int WFIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_w_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_w_tdata,
  input  logic                  s_axis_x_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_x_tdata,
  output logic                  s_axis_x_tready,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  w_overflow
);

  localparam int PTR_W  = $clog2(WFIFO_DEPTH);
  localparam int CNT_W  = $clog2(NO_OF_WEIGHT + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = ACC_WIDTH + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] BIAS   = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic signed [SUM_W-1:0] RES_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  logic [1:0]                   state;
  logic [DATA_WIDTH-1:0]        fifo_mem [WFIFO_DEPTH];
  logic [PTR_W:0]               wr_ptr;
  logic [PTR_W:0]               rd_ptr;
  logic [PTR_W:0]               fifo_count;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         push;
  logic                         pop;
  logic                         fire;
  logic [CNT_W-1:0]             pair_count;
  logic signed [PROD_W-1:0]     product;
  logic                         prod_valid;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_shifted;
  logic signed [SUM_W-1:0]      sum_value;
  logic [DATA_WIDTH-1:0]        relu_value;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W+1)'(WFIFO_DEPTH));

  assign s_axis_x_tready = ((state == IDLE) || (state == ACCUM)) && !fifo_empty &&
                           (pair_count < CNT_W'(NO_OF_WEIGHT));
  assign fire = s_axis_x_tvalid && s_axis_x_tready;
  assign pop  = fire;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the beat.
  assign push = s_axis_w_tvalid && (!fifo_full || pop);

  assign m_axis_tvalid = (state == OUTPUT);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= s_axis_w_tdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      w_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (s_axis_w_tvalid && fifo_full && !pop) w_overflow <= 1'b1;
    end
  end

  // Two-stage datapath: register the full-precision product, accumulate it next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product    <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      prod_valid <= fire;
      if (fire)
        product <= $signed(fifo_mem[rd_ptr[PTR_W-1:0]]) * $signed(s_axis_x_tdata);
      if ((state == OUTPUT) && m_axis_tready)
        acc <= '0;
      else if (prod_valid)
        acc <= acc + {{(ACC_WIDTH-PROD_W){product[PROD_W-1]}}, product};
    end
  end

  always_comb begin
    acc_shifted = acc >>> FRAC_BITS;
    sum_value   = {acc_shifted[ACC_WIDTH-1], acc_shifted} +
                  {{(SUM_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    relu_value  = sum_value[DATA_WIDTH-1:0];
    if (sum_value[SUM_W-1])
      relu_value = '0;
    else if (sum_value > RES_MAX)
      relu_value = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pair_count   <= '0;
      m_axis_tdata <= '0;
    end else begin
      if (fire) pair_count <= pair_count + 1'b1;
      case (state)
        IDLE: begin
          if (fire) state <= ACCUM;
        end
        ACCUM: begin
          if ((pair_count == CNT_W'(NO_OF_WEIGHT)) && !prod_valid) state <= BIAS;
        end
        BIAS: begin
          m_axis_tdata <= relu_value;
          state        <= OUTPUT;
        end
        OUTPUT: begin
          if (m_axis_tready) begin
            state      <= IDLE;
            pair_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
